mem_arbiter: RTL
================

# mem_arbiter

Round-robin read arbiter that shares the single 256x8 memory read port among NREQ testbench/agent requesters. It latches a winner's address, drives the memory's `read`/`enable`/`addr` controls, waits a fixed read latency, then captures `data` and returns it tagged with the requester ID. It sits between the requesters and the memory's DUT-side signals and is the only driver of those controls.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 8, address width
- DW, 8, data width
- RD_LAT, 1, cycles from enable asserted to data valid at `mem_data` (>=1)

- clk  input  1  clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- req  input  NREQ  per-requester request level
- req_addr  input  NREQ*AW  flattened addresses; slice i = requester i
- gnt  output  NREQ  one-hot grant pulse
- rvalid  output  1  read-data valid pulse
- rid  output  $clog2(NREQ)  requester ID for rdata
- rdata  output  DW  captured read data
- busy  output  1  high in any state other than IDLE
- mem_enable  output  1  memory enable
- mem_read  output  1  memory read strobe
- mem_addr  output  AW  memory address
- mem_data  input  DW  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req`, pick winner by round-robin, latch its address and ID, go to ISSUE; else stay.
- ISSUE (1 cycle): `gnt[id]`=1, `mem_enable`=`mem_read`=1, `mem_addr`=latched address; load wait counter with RD_LAT; go to WAIT.
- WAIT: `mem_enable`/`mem_read`/`mem_addr` held; counter decrements; on reaching 1 go to RESP.
- RESP (1 cycle): capture `mem_data` into `rdata`, `rvalid`=1, `rid`=id; drop `mem_enable`/`mem_read`. Arbitrate as in IDLE: any `req` → ISSUE directly, else IDLE.
- Round-robin: pointer = last granted ID; search starts at pointer+1 mod NREQ. Pointer updates only on grant. Reset pointer = NREQ-1, so requester 0 wins first.
- Requester holds `req` and its address stable until `gnt`, drops `req` the cycle after `gnt`. A `req` still high in RESP is treated as a new request.
- Non-winning requests stay pending; no request is ever dropped.
- `req` with no requester granted for it is never lost across reset only if still held after `rst` deasserts.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rid`=0, `rdata`=0, `busy`=0, `mem_enable`=0, `mem_read`=0, `mem_addr`=0; state IDLE.
- `req` sampled high at edge n in IDLE → `gnt` and `mem_enable` high in cycle n+1 → `rvalid` in cycle n+1+RD_LAT+1 (RD_LAT=1: n+3).
- Back-to-back throughput: one read per RD_LAT+2 cycles.
- `gnt` and `rvalid` are single-cycle pulses; never both high for the same transaction.
- Simultaneous requests: exactly one `gnt` bit per ISSUE.
- `rst` mid-operation: next edge returns to IDLE, in-flight read abandoned, no `rvalid`, pointer reset.

## Configuration
- `MEM_ARB_STATS_EN` defined: adds output `gnt_count` (NREQ*16), per-requester grant counters, +1 on each ISSUE for that ID, saturating at 16'hFFFF, cleared to 0 by `rst`.
- Not defined: port and counters absent; arbitration identical.

## Structure
- Package `mem_arb_pkg`: state enum typedef `arb_state_t` (IDLE, ISSUE, WAIT, RESP), constant `GNT_CNT_W`=16.
- Sub-module `rr_picker`: combinational round-robin selector (inputs `req`, pointer; outputs one-hot winner, ID, `any`).
- Top module `mem_arbiter`: FSM, latches, wait counter, optional stats.

## Test plan
- Single: after reset, `req[2]`=1, addr 70, memory holds i>>1 → `gnt[2]` at n+1, `rvalid` at n+3 with `rid`=2, `rdata`=35.
- Contention: `req`=4'b1111 held, addrs 10/20/30/40 → grants in order 0,1,2,3, `rdata` 5,10,15,20, each RD_LAT+2 cycles apart.
- Fairness: `req[0]` and `req[3]` permanently high → grants alternate 0,3,0,3; never two consecutive grants to one ID.
- Latency: RD_LAT=3, addr 150 → `mem_enable` high 4 cycles, `rvalid` at n+5, `rdata`=75.
- Reset mid-read: assert `rst` during WAIT → next cycle all outputs 0, no `rvalid`; a subsequent `req[1]` gets `gnt[1]` ahead of lower-priority-by-pointer ones, confirming pointer reset (requester 0 still wins if also requesting).
- Stats (`MEM_ARB_STATS_EN`): 5 grants to requester 1 → `gnt_count` slice 1 = 5, others 0; preloaded at 16'hFFFF stays 16'hFFFF after another grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory read arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int GNT_CNT_W = 16;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin selector: the first requester after ptr, wrapping, wins.
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         onehot,
    output logic [$clog2(NREQ)-1:0] id,
    output logic                    any
);

    localparam int IDW = $clog2(NREQ);

    always_comb begin
        int idx;
        onehot = '0;
        id     = '0;
        any    = |req;
        idx    = 0;
        // Walk from the farthest slot to the nearest so the nearest requester overwrites.
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx[IDW-1:0]]) begin
                onehot               = '0;
                onehot[idx[IDW-1:0]] = 1'b1;
                id                   = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read port among NREQ requesters.
// Optional per-requester grant counters are enabled with MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      req_addr,
    output logic [NREQ-1:0]         gnt,
    output logic                    rvalid,
    output logic [$clog2(NREQ)-1:0] rid,
    output logic [DW-1:0]           rdata,
    output logic                    busy,
    output logic                    mem_enable,
    output logic                    mem_read,
    output logic [AW-1:0]           mem_addr,
    input  logic [DW-1:0]           mem_data,
`ifdef MEM_ARB_STATS_EN
    output logic [NREQ*GNT_CNT_W-1:0] gnt_count,
`endif
    output arb_state_t              dbg_state
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(RD_LAT + 1);

    arb_state_t     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cur_id;
    logic [CW-1:0]  wcnt;

    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .id     (pick_id),
        .any    (pick_any)
    );

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);
            cur_id     <= '0;
            wcnt       <= '0;
            gnt        <= '0;
            rvalid     <= 1'b0;
            rid        <= '0;
            rdata      <= '0;
            mem_enable <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
        end else begin
            gnt    <= '0;
            rvalid <= 1'b0;
            case (state)
                // RESP arbitrates exactly like IDLE so back-to-back reads skip IDLE.
                IDLE, RESP: begin
                    if (pick_any) begin
                        state      <= ISSUE;
                        gnt        <= pick_oh;
                        cur_id     <= pick_id;
                        ptr        <= pick_id;
                        mem_enable <= 1'b1;
                        mem_read   <= 1'b1;
                        mem_addr   <= req_addr[int'(pick_id)*AW +: AW];
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    wcnt  <= CW'(RD_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    // Data is valid during the last WAIT cycle; registering it presents it in RESP.
                    if (wcnt == CW'(1)) begin
                        state      <= RESP;
                        mem_enable <= 1'b0;
                        mem_read   <= 1'b0;
                        rvalid     <= 1'b1;
                        rid        <= cur_id;
                        rdata      <= mem_data;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [GNT_CNT_W-1:0] cnt [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else if (state == ISSUE && cnt[cur_id] != '1) begin
            cnt[cur_id] <= cnt[cur_id] + 1'b1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign gnt_count[g*GNT_CNT_W +: GNT_CNT_W] = cnt[g];
    end
`endif

endmodule
